joy_db15_conditioner: RTL and testbench
=======================================

# joy_db15_conditioner

Conditions the two raw 16-bit active-high button words produced by the DB15 splitter reader before they reach the core's input mapping. Inputs are resynchronised into the system clock domain, debounced per bit on a divided sample tick, checked for an absent or unpowered splitter, and given per-button autofire. Single-cycle press pulses are produced for coin/start edge logic.

## Interface
- DB_TICKS, 48000: system clocks per debounce sample tick (1 ms at 48 MHz); range 2..2^20.
- DB_COUNT, 4: consecutive disagreeing ticks required to flip a debounced bit; range 1..15.
- AF_HALF, 33: sample ticks per autofire half-period; range 1..255.
- clk  in  1  system clock, 48-50 MHz.
- reset  in  1  asynchronous, active-high reset.
- joy1_in  in  16  raw player 1 word, active-high, layout {4'b0, Select, Start, F, E, D, C, B, A, Up, Down, Left, Right}; asynchronous to clk.
- joy2_in  in  16  raw player 2 word, same layout.
- af_en  in  16  per-bit autofire enable, applied to both players; static or quasi-static.
- joy1_out  out  16  conditioned player 1 word, active-high.
- joy2_out  out  16  conditioned player 2 word.
- joy1_press  out  16  one-cycle pulse per bit on debounced 0->1 of player 1.
- joy2_press  out  16  same for player 2.
- joy1_valid  out  1  player 1 word plausible (splitter present).
- joy2_valid  out  1  player 2 word plausible.

## Operation
- Synchroniser: two flops per input bit (32 bits); all later logic uses the second stage only.
- Tick generator: counter 0..DB_TICKS-1; tick asserted for one clk when counter = DB_TICKS-1, counter wraps to 0 the same edge.
- Debounce, per bit (32 instances): stable bit S, counter C of width clog2(DB_COUNT+1).
  - On tick, sync == S: C <= 0.
  - On tick, sync != S and C < DB_COUNT-1: C <= C+1.
  - On tick, sync != S and C == DB_COUNT-1: S <= sync, C <= 0.
  - No tick: S, C hold. A single agreeing sample restarts the count.
- Validity: player word invalid when debounced Up&Down both 1 AND Left&Right both 1 (splitter data line stuck low). joyN_valid <= !invalid. While invalid, joyN_out and joyN_press forced to 0.
- Press: joyN_press[i] <= tick & S flips 0->1 & valid-after-update. 1->0 flips produce no pulse. Autofire does not generate press pulses.
- Autofire: tick counter A (0..AF_HALF-1) and phase bit P. On tick, A increments; at AF_HALF-1 wraps to 0 and P toggles.
  - Restart: if any press pulse (either player) lands on a bit with af_en=1, A <= 0, P <= 1 on that edge; restart overrides a simultaneous wrap/toggle.
  - joyN_out[i] <= valid ? S[i] & (!af_en[i] | P) : 0.
- Bits 15:12 pass through the same path; the splitter drives them 0 so they stay 0.

## Timing
- Reset values: joy1_out = joy2_out = 16'h0000, press = 16'h0000, valid = 1, all S = 0, all C = 0, tick counter = 0, A = 0, P = 1, synchroniser flops = 0.
- Reset is asynchronous assert; deassertion is used synchronously by the integrator. Reset mid-debounce discards partial counts.
- Latency from input change to joyN_out: 2 clk (sync) + wait to next tick + (DB_COUNT-1) further ticks + 1 clk register. Minimum 3 + (DB_COUNT-1)*DB_TICKS clk when the change arrives just ahead of a tick.
- joyN_press pulse and the first cycle of the new joyN_out value appear on the same clk edge; pulse width exactly 1 clk.
- Autofire toggles only on tick edges; full period = 2*AF_HALF ticks; first shot after restart is immediate (P = 1).
- Validity evaluated from post-update S; a word becoming invalid zeroes outputs on the same edge S updates.

## Test plan
- Params DB_TICKS=4, DB_COUNT=3, AF_HALF=2. Reset, hold inputs 0 -> all outputs 0, valid=1 for 100 clk.
- joy1_in[4] 0->1 held -> joy1_out[4]=1 and joy1_press[4]=1 for exactly 1 clk, 3..4 + 2*4 clk after change; joy1_press returns 0.
- Glitch: joy1_in[0] high for 2 ticks, low 1 tick, high 3 ticks -> no output change until third tick of final run; single press pulse.
- joy2_in = 16'h0FFF held -> after debounce joy2_valid=0, joy2_out=0, no joy2_press; return to 16'h0010 -> valid=1, joy2_out=16'h0010, press[4] pulse.
- af_en=16'h0010, joy1_in[4] held -> joy1_out[4] high 2 ticks, low 2 ticks, repeating; releasing stops within debounce latency; re-press restarts with output high immediately.
- Assert reset mid-count (C=2) -> all outputs 0 immediately; after release, full DB_COUNT ticks required again.

Source files
------------

// File: rtl/joy_db15_conditioner.sv
// joy_db15_conditioner
//   Conditions the two raw DB15 splitter button words before the core's
//   input mapping: 2-flop resync, per-bit tick-sampled debounce, an
//   absent-splitter check, per-button autofire and press pulses.
// Ports:
//   clk, reset            system clock, async active-high reset
//   joy1_in, joy2_in      raw active-high words {4'b0,Sel,Start,F..A,U,D,L,R}
//   af_en                 per-bit autofire enable, shared by both players
//   joy1_out, joy2_out    conditioned words (zero while the word is invalid)
//   joy1_press, joy2_press one-clk pulse on a debounced 0->1
//   joy1_valid, joy2_valid word plausible (splitter present)

// Per-bit debouncer. s_nxt is exported so the top can evaluate validity,
// presses and outputs from the post-update state on the same edge.
module joy_db15_debounce #(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic d,
  output logic s,
  output logic s_nxt
);
  localparam int CW = $clog2(DB_COUNT + 1);

  logic [CW-1:0] c, c_nxt;

  // A single agreeing sample restarts the count; DB_COUNT consecutive
  // disagreeing samples flip the stable bit.
  always_comb begin
    s_nxt = s;
    c_nxt = c;
    if (tick) begin
      if (d == s)                       c_nxt = '0;
      else if (c == CW'(DB_COUNT - 1)) begin
        s_nxt = d;
        c_nxt = '0;
      end else                          c_nxt = c + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s <= 1'b0;
      c <= '0;
    end else begin
      s <= s_nxt;
      c <= c_nxt;
    end
  end
endmodule

module joy_db15_conditioner #(
  parameter int DB_TICKS = 48000,
  parameter int DB_COUNT = 4,
  parameter int AF_HALF  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joy1_in,
  input  logic [15:0] joy2_in,
  input  logic [15:0] af_en,
  output logic [15:0] joy1_out,
  output logic [15:0] joy2_out,
  output logic [15:0] joy1_press,
  output logic [15:0] joy2_press,
  output logic        joy1_valid,
  output logic        joy2_valid
);
  localparam int TW = $clog2(DB_TICKS);
  localparam int AW = $clog2(AF_HALF + 1);

  logic [1:0][15:0] sync1, sync2, s, s_nxt, press_nxt, out_nxt, out_q, press_q;
  logic [1:0]       valid_nxt, valid_q;
  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [AW-1:0]    a, a_nxt;
  logic             ph, ph_nxt, restart;

  // Resynchroniser; index 0 = player 1, index 1 = player 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {joy2_in, joy1_in};
      sync2 <= sync1;
    end
  end

  // Debounce sample tick.
  assign tick = (tcnt == TW'(DB_TICKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  for (genvar p = 0; p < 2; p++) begin : g_pl
    for (genvar b = 0; b < 16; b++) begin : g_bit
      joy_db15_debounce #(.DB_COUNT(DB_COUNT)) u_db (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .d     (sync2[p][b]),
        .s     (s[p][b]),
        .s_nxt (s_nxt[p][b])
      );
    end

    // A dead splitter data line reads as every button pressed, which shows
    // up as the impossible Up+Down and Left+Right combination.
    assign valid_nxt[p] = ~&s_nxt[p][3:0];
    assign press_nxt[p] = {16{tick & valid_nxt[p]}} & ~s[p] & s_nxt[p];
    assign out_nxt[p]   = valid_nxt[p] ? (s_nxt[p] & (~af_en | {16{ph_nxt}})) : 16'h0000;
  end

  // Autofire phase. A fresh press on an autofire button restarts the
  // phase so the first shot fires on the press edge itself.
  assign restart = |((press_nxt[0] | press_nxt[1]) & af_en);

  always_comb begin
    a_nxt  = a;
    ph_nxt = ph;
    if (restart) begin
      a_nxt  = '0;
      ph_nxt = 1'b1;
    end else if (tick) begin
      if (a == AW'(AF_HALF - 1)) begin
        a_nxt  = '0;
        ph_nxt = ~ph;
      end else begin
        a_nxt  = a + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a       <= '0;
      ph      <= 1'b1;
      out_q   <= '0;
      press_q <= '0;
      valid_q <= 2'b11;
    end else begin
      a       <= a_nxt;
      ph      <= ph_nxt;
      out_q   <= out_nxt;
      press_q <= press_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign joy1_out   = out_q[0];
  assign joy2_out   = out_q[1];
  assign joy1_press = press_q[0];
  assign joy2_press = press_q[1];
  assign joy1_valid = valid_q[0];
  assign joy2_valid = valid_q[1];
endmodule

// File: tb/tb_joy_db15_conditioner.sv
module tb_joy_db15_conditioner;
  localparam int DBT = 4;
  localparam int DBC = 3;
  localparam int AFH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joy1_in = '0, joy2_in = '0, af_en = '0;
  logic [15:0] joy1_out, joy2_out, joy1_press, joy2_press;
  logic        joy1_valid, joy2_valid;

  always #5 clk = ~clk;

  joy_db15_conditioner #(.DB_TICKS(DBT), .DB_COUNT(DBC), .AF_HALF(AFH)) dut (
    .clk        (clk),
    .reset      (reset),
    .joy1_in    (joy1_in),
    .joy2_in    (joy2_in),
    .af_en      (af_en),
    .joy1_out   (joy1_out),
    .joy2_out   (joy2_out),
    .joy1_press (joy1_press),
    .joy2_press (joy2_press),
    .joy1_valid (joy1_valid),
    .joy2_valid (joy2_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce: a bit's stable value follows the sampled input once DBC
  // consecutive tick samples disagree with it. Autofire phase is derived
  // from the number of ticks since the last restart.
  logic [31:0] m_sy1 = '0, m_sy2 = '0, m_st = '0, nst;
  int          m_run [32];
  int          m_cyc = 0, m_tsr = 0;
  bit          tk, ph;
  logic [1:0]  mv;
  logic [15:0] p0, p1;
  logic [15:0] e_out1 = '0, e_out2 = '0, e_pr1 = '0, e_pr2 = '0;
  logic        e_v1 = 1'b1, e_v2 = 1'b1;
  int          pc1_0 = 0, pc2 = 0;

  initial begin
    for (int i = 0; i < 32; i++) m_run[i] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_sy1 = '0; m_sy2 = '0; m_st = '0; m_cyc = 0; m_tsr = 0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
        e_out1 = '0; e_out2 = '0; e_pr1 = '0; e_pr2 = '0; e_v1 = 1'b1; e_v2 = 1'b1;
      end else begin
        tk = ((m_cyc % DBT) == DBT - 1);
        m_cyc++;
        nst = m_st;
        if (tk) begin
          for (int i = 0; i < 32; i++) begin
            if (m_sy2[i] == m_st[i]) m_run[i] = 0;
            else begin
              m_run[i] = m_run[i] + 1;
              if (m_run[i] == DBC) begin
                nst[i]   = m_sy2[i];
                m_run[i] = 0;
              end
            end
          end
        end
        mv[0] = (nst[3:0]   != 4'hF);
        mv[1] = (nst[19:16] != 4'hF);
        p0 = (tk && mv[0]) ? (nst[15:0]  & ~m_st[15:0])  : 16'h0;
        p1 = (tk && mv[1]) ? (nst[31:16] & ~m_st[31:16]) : 16'h0;
        if (|((p0 | p1) & af_en)) m_tsr = 0;
        else if (tk)              m_tsr++;
        ph = (((m_tsr / AFH) % 2) == 0);
        e_out1 = mv[0] ? (nst[15:0]  & (~af_en | {16{ph}})) : 16'h0;
        e_out2 = mv[1] ? (nst[31:16] & (~af_en | {16{ph}})) : 16'h0;
        e_pr1 = p0; e_pr2 = p1; e_v1 = mv[0]; e_v2 = mv[1];
        m_st  = nst;
        m_sy2 = m_sy1;
        m_sy1 = {joy2_in, joy1_in};
      end
      #1;
      chk("cycle", 96'({joy2_valid, joy1_valid, joy2_press, joy1_press, joy2_out, joy1_out}),
                   96'({e_v2, e_v1, e_pr2, e_pr1, e_out2, e_out1}));
      if (joy1_press[0]) pc1_0++;
      pc2 += $countones(joy2_press);
    end
  end

  // ---------------- directed stimulus ----------------
  // Wait for the negedge just after a tick edge so change latency is fixed.
  task automatic align();
    @(negedge clk);
    while ((m_cyc % DBT) != 0) @(negedge clk);
  endtask

  task automatic wait_press(input int pl, input int b, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if ((pl == 1) ? joy1_press[b] : joy2_press[b]) begin
        lat = n;
        break;
      end
    end
  endtask

  int          lat, n0, n2;
  logic [7:0]  afpat;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_outs",  96'({joy1_out, joy2_out, joy1_press, joy2_press}), 96'(0));
    chk("idle_valid", 96'({joy1_valid, joy2_valid}), 96'(2'b11));

    // single press: 2 sync edges, ticks at +4,+8,+12
    align(); joy1_in = 16'h0010;
    wait_press(1, 4, lat);
    chk("p1_latency", 96'(lat), 96'(12));
    chk("p1_out",     96'(joy1_out), 96'(16'h0010));
    @(posedge clk); #1;
    chk("p1_pulse_w", 96'(joy1_press), 96'(0));
    chk("p1_hold",    96'(joy1_out), 96'(16'h0010));
    @(negedge clk); joy1_in = 16'h0000;
    repeat (20) @(negedge clk);
    chk("p1_release", 96'(joy1_out), 96'(0));

    // glitch: high 2 ticks, low 1 tick, high 3 ticks
    n0 = pc1_0;
    align(); joy1_in = 16'h0001;
    repeat (8) @(negedge clk); joy1_in = 16'h0000;
    repeat (4) @(negedge clk); joy1_in = 16'h0001;
    wait_press(1, 0, lat);
    chk("glitch_latency", 96'(lat), 96'(12));
    repeat (20) @(negedge clk);
    chk("glitch_pulses", 96'(pc1_0 - n0), 96'(1));
    joy1_in = 16'h0000;
    repeat (20) @(negedge clk);

    // stuck-low splitter on player 2
    n2 = pc2;
    align(); joy2_in = 16'h0FFF;
    repeat (16) @(negedge clk);
    chk("inv_valid",  96'(joy2_valid), 96'(0));
    chk("inv_out",    96'(joy2_out), 96'(0));
    chk("inv_pulses", 96'(pc2 - n2), 96'(0));
    chk("inv_p1_ok",  96'(joy1_valid), 96'(1));
    // bit 4 was already debounced high under the invalid word, so clear
    // the word first to get a genuine rising edge on it
    align(); joy2_in = 16'h0000;
    repeat (16) @(negedge clk);
    chk("rec_valid", 96'(joy2_valid), 96'(1));
    chk("rec_out0",  96'(joy2_out), 96'(0));
    align(); joy2_in = 16'h0010;
    wait_press(2, 4, lat);
    chk("rec_latency", 96'(lat), 96'(12));
    chk("rec_out",     96'(joy2_out), 96'(16'h0010));

    // autofire on bit 4 (joy2_out[4] also toggles; the model tracks it)
    @(negedge clk); af_en = 16'h0010;
    align(); joy1_in = 16'h0010;
    wait_press(1, 4, lat);
    chk("af_latency", 96'(lat), 96'(12));
    chk("af_first",   96'(joy1_out[4]), 96'(1));
    afpat = 8'b1001_1001;
    for (int k = 0; k < 8; k++) begin
      repeat (DBT) @(posedge clk); #1;
      chk($sformatf("af_tick%0d", k + 1), 96'(joy1_out[4]), 96'(afpat[k]));
    end
    @(negedge clk); joy1_in = 16'h0000;
    repeat (20) @(negedge clk);
    chk("af_release", 96'(joy1_out), 96'(0));
    align(); joy1_in = 16'h0010;
    wait_press(1, 4, lat);
    chk("af_restart_lat",  96'(lat), 96'(12));
    chk("af_restart_high", 96'(joy1_out[4]), 96'(1));

    // reset mid-count
    @(negedge clk); af_en = 16'h0000; joy1_in = 16'h0000;
    repeat (20) @(negedge clk);
    align(); joy1_in = 16'h0020;
    repeat (8) @(negedge clk);
    chk("pre_rst_p2", 96'(joy2_out), 96'(16'h0010));
    reset = 1'b1; #1;
    chk("rst_outs",  96'({joy1_out, joy2_out, joy1_press, joy2_press}), 96'(0));
    chk("rst_valid", 96'({joy1_valid, joy2_valid}), 96'(2'b11));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_press(1, 5, lat);
    chk("rst_recount", 96'(lat), 96'(12));
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
